// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access arbiter.
package dmem_pkg;

  localparam int unsigned DMEM_BYTES  = 128;
  localparam int unsigned DMEM_ADDR_W = 16;
  localparam int unsigned DMEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  // A word at addr needs addr+1 to exist; addr == DMEM_BYTES-1 is rejected too.
  function automatic logic addr_in_range(input logic [DMEM_ADDR_W-1:0] addr);
    return addr < DMEM_ADDR_W'(DMEM_BYTES - 1);
  endfunction

endpackage

// File: rtl/dmem_req_select.sv
// Combinational winner pick and payload mux between the CPU and debug ports.
module dmem_req_select
  import dmem_pkg::*;
(
  input  logic      i_cpu_req,
  input  dmem_req_t i_cpu,
  input  logic      i_dbg_req,
  input  dmem_req_t i_dbg,
  input  owner_t    i_prio,
  output logic      o_any_c,
  output owner_t    o_owner_c,
  output dmem_req_t o_sel_c
);

  owner_t w_owner;

  always_comb begin
    w_owner = OWN_CPU;
    if (i_cpu_req && i_dbg_req) begin
      w_owner = i_prio;
    end else if (i_dbg_req) begin
      w_owner = OWN_DBG;
    end
    o_any_c   = i_cpu_req | i_dbg_req;
    o_owner_c = w_owner;
    o_sel_c   = (w_owner == OWN_DBG) ? i_dbg : i_cpu;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory access controller (IDLE -> ACCESS -> RESP per access).
// Optional round-robin arbitration: define DMEM_ARB_ROUND_ROBIN_EN.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [DMEM_ADDR_W-1:0] cpu_addr,
  input  logic [DMEM_DATA_W-1:0] cpu_wdata,
  output logic                   cpu_done,
  output logic [DMEM_DATA_W-1:0] cpu_rdata,
  input  logic                   dbg_req,
  input  logic                   dbg_we,
  input  logic [DMEM_ADDR_W-1:0] dbg_addr,
  input  logic [DMEM_DATA_W-1:0] dbg_wdata,
  output logic                   dbg_done,
  output logic [DMEM_DATA_W-1:0] dbg_rdata,
  output logic                   err,
  output logic [DMEM_ADDR_W-1:0] mem_address,
  output logic [DMEM_DATA_W-1:0] mem_write_data,
  output logic                   mem_write,
  output logic                   mem_read,
  input  logic [DMEM_DATA_W-1:0] mem_read_data
);

  state_t                 r_state;
  state_t                 w_next_state;
  owner_t                 r_owner;
  owner_t                 w_owner;
  owner_t                 w_prio;
  logic                   w_any;
  logic                   w_ok;
  logic                   w_grant;
  dmem_req_t              w_cpu_pl;
  dmem_req_t              w_dbg_pl;
  dmem_req_t              w_sel;
  logic                   r_ok;
  logic                   r_cpu_done;
  logic                   r_dbg_done;
  logic                   r_err;
  logic [DMEM_DATA_W-1:0] r_cpu_rdata;
  logic [DMEM_DATA_W-1:0] r_dbg_rdata;
  logic [DMEM_ADDR_W-1:0] r_mem_address;
  logic [DMEM_DATA_W-1:0] r_mem_write_data;
  logic                   r_mem_write;
  logic                   r_mem_read;

  assign w_cpu_pl = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign w_dbg_pl = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};

  dmem_req_select u_sel (
    .i_cpu_req (cpu_req),
    .i_cpu     (w_cpu_pl),
    .i_dbg_req (dbg_req),
    .i_dbg     (w_dbg_pl),
    .i_prio    (w_prio),
    .o_any_c   (w_any),
    .o_owner_c (w_owner),
    .o_sel_c   (w_sel)
  );

  assign w_ok    = addr_in_range(w_sel.addr);
  assign w_grant = (r_state == IDLE) && w_any;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  owner_t r_prio;

  // Pointer moves to the port not just granted.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_prio <= OWN_CPU;
    end else if (w_grant) begin
      r_prio <= (w_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end
  end

  assign w_prio = r_prio;
`else
  assign w_prio = OWN_CPU;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next_state = ACCESS;
      ACCESS:  w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Strobes are launched on the IDLE->ACCESS edge so they are valid for exactly the ACCESS cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_owner          <= OWN_CPU;
      r_ok             <= 1'b0;
      r_cpu_done       <= 1'b0;
      r_dbg_done       <= 1'b0;
      r_err            <= 1'b0;
      r_cpu_rdata      <= '0;
      r_dbg_rdata      <= '0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_mem_write      <= 1'b0;
      r_mem_read       <= 1'b0;
    end else begin
      r_cpu_done  <= 1'b0;
      r_dbg_done  <= 1'b0;
      r_err       <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner          <= w_owner;
            r_ok             <= w_ok;
            r_mem_address    <= w_sel.addr;
            r_mem_write_data <= w_sel.wdata;
            r_mem_write      <= w_sel.we & w_ok;
            r_mem_read       <= ~w_sel.we & w_ok;
          end
        end
        ACCESS: begin
          if (r_mem_read) begin
            if (r_owner == OWN_CPU) r_cpu_rdata <= mem_read_data;
            else                    r_dbg_rdata <= mem_read_data;
          end
          r_cpu_done <= (r_owner == OWN_CPU);
          r_dbg_done <= (r_owner == OWN_DBG);
          r_err      <= ~r_ok;
        end
        default: ;
      endcase
    end
  end

  assign cpu_done       = r_cpu_done;
  assign dbg_done       = r_dbg_done;
  assign err            = r_err;
  assign cpu_rdata      = r_cpu_rdata;
  assign dbg_rdata      = r_dbg_rdata;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;
  assign mem_write      = r_mem_write;
  assign mem_read       = r_mem_read;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester access controller in front of the 16-bit byte-addressed, big-endian data memory (128 bytes). It arbitrates the CPU load/store port and the debug/loader port, and runs each accepted access as a fixed three-state sequence. It range-checks each address and drives the memory's Address, WriteData, MemWrite and MemRead inputs. It also registers read data back to the granted requester.

Parameters:
MEM_BYTES, 128, data memory size in bytes; a word access at A is legal only if A+1 <= MEM_BYTES-1.
ADDR_W, 16, address width on all ports.
DATA_W, 16, word width; always two bytes, big-endian.

Ports:
Clock  in  1  rising-edge clock, shared with data memory
Reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held until cpu_done
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  16  byte address of the high byte
cpu_wdata  in  16  store data
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  16  load data; valid while cpu_done=1
dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/16/16  debug port, same meaning as the CPU port
dbg_done, dbg_rdata  out  1/16  debug completion and read data
err  out  1  pulses with done when the address was out of range
mem_address  out  16  to data memory Address
mem_write_data  out  16  to data memory WriteData
mem_write  out  1  to MemWrite
mem_read  out  1  to MemRead
mem_read_data  in  16  from ReadData (combinational read)

Behaviour:
- States: IDLE, ACCESS, RESP. Owner register: CPU or DBG.
- Reset values: state=IDLE, every output 0, priority pointer=CPU. Reset in any state aborts the access, and mem_write is 0 from the next cycle. No done pulse is issued for an aborted access.
- IDLE: if any req=1, latch the winner's we/addr/wdata and owner, then go to ACCESS. With no req, stay in IDLE.
- Arbitration, default: CPU has fixed priority over DBG. When both requests are asserted in the same cycle, the CPU wins.
- Range check at latch time: out of range if addr >= MEM_BYTES-1 (this covers addr[15:7]!=0 and addr==127). An out-of-range access skips the memory strobes and still goes ACCESS then RESP, with err=1 in RESP.
- ACCESS, one cycle:
  - mem_address = latched addr.
  - store: mem_write=1, mem_write_data = wdata. The memory commits both bytes at the end of this cycle.
  - load: mem_read=1. The controller captures mem_read_data into the owner's rdata register at the end of this cycle.
  - Strobes are 0 in every other state.
- RESP, one cycle: the owner's done=1, err as computed, then return to IDLE. The other port's done stays 0.
- Latency: request sampled at edge t, ACCESS in cycle t+1, done in cycle t+2. Minimum spacing between accepted accesses is 3 cycles.
- rdata holds its value after done until the next load by the same port. A store does not change rdata.
- A requester deasserting req before done is a protocol violation; the access still completes.
- A request still asserted in the RESP cycle is re-arbitrated in IDLE on the next cycle, not in RESP.

Optional Feature:
Macro DMEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit priority pointer points at the port not most recently served. A simultaneous request goes to the pointer's port. The pointer updates on entry to ACCESS.
- Undefined: fixed CPU priority, no pointer register.

Decomposition:
- Shared package dmem_pkg:
  - state enum (IDLE, ACCESS, RESP)
  - owner enum (OWN_CPU, OWN_DBG)
  - localparam DMEM_BYTES=128
  - word-width constant
- One natural sub-module, dmem_req_select: a combinational winner pick plus payload mux from the two req inputs and the priority pointer. Everything else stays in the top module.

Test Plan:
1. Reset with cpu_req=1 held -> all outputs 0 while Reset=1. First done arrives 2 cycles after Reset falls.
2. CPU store addr=0x0010, wdata=0xABCD -> mem_write=1 for exactly 1 cycle with mem_address=0x0010. cpu_done pulses 2 cycles after req; a subsequent load of 0x0010 gives cpu_rdata=0xABCD.
3. DBG load addr=0x007F (127) -> no mem_read, and dbg_done=1 with err=1. Repeat at addr=0x0200 -> same result. Repeat at addr=0x007E -> err=0.
4. cpu_req and dbg_req rise in the same cycle -> CPU served first, DBG done 3 cycles after cpu_done. With DMEM_ARB_ROUND_ROBIN_EN and both held, grants alternate CPU, DBG, CPU.
5. Assert Reset during the ACCESS of a store -> mem_write=0 after that edge, no cpu_done, and the FSM is in IDLE.
6. Back-to-back CPU loads of 0x0000 then 0x0002 with memory preloaded 0x1234, 0x5678 -> cpu_rdata=0x1234, then 0x5678. Each done is a single-cycle pulse.
